// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate D-cache controller; read hit 0 stalls, miss/write = ack wait + 1.
// Stalls the pipeline while memory is busy; optional saturating hit/miss counters under DCACHE_PERF_EN.
module dcache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iReq,
    input  logic                  iWriteEn,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [DATA_WIDTH-1:0] iWData,
    output logic [DATA_WIDTH-1:0] oRData,
    output logic                  oStall,
    output logic                  oMemReq,
    output logic                  oMemWe,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0] oMemWData,
    input  logic [DATA_WIDTH-1:0] iMemRData,
    input  logic                  iMemAck,
    output logic [31:0]           oHitCount,
    output logic [31:0]           oMissCount
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];
    logic [DATA_WIDTH-1:0] fill_q, fill_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  req_ok;
    logic                  tag_match;
    logic                  fill_en;
    logic                  wr_upd_en;

    assign idx       = iAddr[INDEX_BITS+1:2];
    assign tag       = iAddr[ADDR_WIDTH-1:INDEX_BITS+2];
    // Requests are ignored while reset is held so the stall output stays low.
    assign req_ok    = iReq & rst_n;
    assign tag_match = valid_q[idx] && (tag_q[idx] == tag);

    assign oMemAddr  = iAddr & ~(ADDR_WIDTH'(3));
    assign oMemWData = iWData;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        oStall    = 1'b0;
        oMemReq   = 1'b0;
        oMemWe    = 1'b0;
        oRData    = '0;
        fill_en   = 1'b0;
        wr_upd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    if (iWriteEn) begin
                        oStall  = 1'b1;
                        state_d = WR_THRU;
                    end else if (tag_match) begin
                        oRData  = data_q[idx];
                    end else begin
                        oStall  = 1'b1;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                oStall  = 1'b1;
                oMemReq = 1'b1;
                if (iMemAck) begin
                    fill_en = 1'b1;
                    fill_d  = iMemRData;
                    state_d = DONE;
                end
            end
            WR_THRU: begin
                oStall  = 1'b1;
                oMemReq = 1'b1;
                oMemWe  = 1'b1;
                if (iMemAck) begin
                    wr_upd_en = tag_match;
                    fill_d    = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                oRData  = fill_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; the valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= iMemRData;
        end else if (wr_upd_en) begin
            data_q[idx] <= iWData;
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        hit_evt;
    logic        miss_evt;

    assign hit_evt  = (state_q == IDLE) && req_ok && !iWriteEn && tag_match;
    assign miss_evt = (state_q == IDLE) && req_ok && !iWriteEn && !tag_match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign oHitCount  = hit_cnt_q;
    assign oMissCount = miss_cnt_q;
`else
    assign oHitCount  = 32'h0;
    assign oMissCount = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, multi-cycle reset/ack corner cases, and a random
// access stream compared against a simple array model of a direct-mapped write-through cache.
module tb_dcache_ctrl;
`ifdef DCACHE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        iReq;
    logic        iWriteEn;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic [31:0] oRData;
    logic        oStall;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData;
    logic        iMemAck;
    logic [31:0] oHitCount;
    logic [31:0] oMissCount;

    int checks = 0;
    int errors = 0;

    dcache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iReq       (iReq),
        .iWriteEn   (iWriteEn),
        .iAddr      (iAddr),
        .iWData     (iWData),
        .oRData     (oRData),
        .oStall     (oStall),
        .oMemReq    (oMemReq),
        .oMemWe     (oMemWe),
        .oMemAddr   (oMemAddr),
        .oMemWData  (oMemWData),
        .iMemRData  (iMemRData),
        .iMemAck    (iMemAck),
        .oHitCount  (oHitCount),
        .oMissCount (oMissCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory contents; untouched words read back as a fixed function of their address.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_1234;
    endfunction

    // Reference cache: one word per line, index = word address mod 16, tag = address / 64.
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          m_hits;
    int          m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        iReq    = 1'b0;
        iMemAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // Drives one CPU access to completion, playing the memory side with an ack on the
    // dly-th cycle of the request. Returns stall cycles, request count and load data.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, output int stalls, output int reqs,
                          output logic [31:0] rd);
        int          req_cyc;
        logic        prev_req;
        logic [31:0] wa;
        wa       = addr & 32'hFFFF_FFFC;
        stalls   = 0;
        reqs     = 0;
        rd       = '0;
        req_cyc  = 0;
        prev_req = 1'b0;
        iReq     = 1'b1;
        iWriteEn = we;
        iAddr    = addr;
        iWData   = wd;
        iMemAck  = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (oMemReq && !prev_req) reqs++;
            prev_req = oMemReq;
            if (!oStall) begin
                rd = oRData;
                @(posedge clk);
                #1;
                iReq    = 1'b0;
                iMemAck = 1'b0;
                return;
            end
            stalls++;
            if (oMemReq) begin
                req_cyc++;
                chk("mem_we", {31'b0, oMemWe}, {31'b0, we});
                chk("mem_addr", oMemAddr, wa);
                if (we) chk("mem_wdata", oMemWData, wd);
                if (req_cyc == dly) begin
                    iMemAck = 1'b1;
                    if (we) mem[wa] = wd;
                    else    iMemRData = memrd(wa);
                end
            end
            @(posedge clk);
            #1;
            iMemAck = 1'b0;
        end
        checks++;
        errors++;
        $display("FAIL access_timeout: addr %h still stalled after 64 cycles", addr);
        iReq = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          dly;
        int          exp_stalls;
        logic [31:0] exp_rd;
        logic        chk_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          st;
        int          rq;
        logic [31:0] rd;

        rst_n     = 1'b0;
        iReq      = 1'b0;
        iWriteEn  = 1'b0;
        iAddr     = '0;
        iWData    = '0;
        iMemRData = '0;
        iMemAck   = 1'b0;
        mem[32'h40]  = 32'hDEAD_BEEF;
        mem[32'h440] = 32'h0BAD_F00D;

        vecs[0] = '{1'b0, 32'h040, 32'h0,         3, 4, 32'hDEAD_BEEF, 1'b1};
        vecs[1] = '{1'b0, 32'h040, 32'h0,         3, 0, 32'hDEAD_BEEF, 1'b1};
        vecs[2] = '{1'b0, 32'h440, 32'h0,         2, 3, 32'h0BAD_F00D, 1'b1};
        vecs[3] = '{1'b0, 32'h040, 32'h0,         1, 2, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b0, 32'h440, 32'h0,         1, 2, 32'h0BAD_F00D, 1'b1};
        vecs[5] = '{1'b1, 32'h440, 32'h1234_5678, 2, 3, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 32'h440, 32'h0,         1, 0, 32'h1234_5678, 1'b1};
        vecs[7] = '{1'b1, 32'h080, 32'hCAFE_F00D, 1, 2, 32'h0,         1'b0};
        vecs[8] = '{1'b0, 32'h080, 32'h0,         2, 3, 32'hCAFE_F00D, 1'b1};
        vecs[9] = '{1'b0, 32'h440, 32'h0,         1, 2, 32'h1234_5678, 1'b1};

        do_reset();
        @(negedge clk);
        chk("rst_stall", {31'b0, oStall}, 32'h0);
        chk("rst_memreq", {31'b0, oMemReq}, 32'h0);
        chk("rst_rdata", oRData, 32'h0);
        chk("rst_hits", oHitCount, 32'h0);
        chk("rst_miss", oMissCount, 32'h0);
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dly, st, rq, rd);
            chk($sformatf("vec%0d_stalls", i), st, vecs[i].exp_stalls);
            chk($sformatf("vec%0d_reqs", i), rq, (vecs[i].exp_stalls != 0) ? 1 : 0);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            if (i == 1) chk("hits_after_first_hit", oHitCount, PERF ? 32'd1 : 32'd0);
        end
        chk("table_hits", oHitCount, PERF ? 32'd2 : 32'd0);
        chk("table_miss", oMissCount, PERF ? 32'd6 : 32'd0);

        // Reset in the middle of a read miss, with an ack arriving in the same cycle
        do_reset();
        access(1'b0, 32'h40, 32'h0, 1, st, rq, rd);
        chk("pre_rst_fill_stalls", st, 2);
        iReq     = 1'b1;
        iWriteEn = 1'b0;
        iAddr    = 32'h50;
        @(negedge clk);
        chk("miss_stall_same_cycle", {31'b0, oStall}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rd_miss_req", {31'b0, oMemReq}, 32'h1);
        rst_n     = 1'b0;
        iMemAck   = 1'b1;
        iMemRData = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        iMemAck = 1'b0;
        @(negedge clk);
        chk("midrst_memreq", {31'b0, oMemReq}, 32'h0);
        chk("midrst_stall", {31'b0, oStall}, 32'h0);
        chk("midrst_rdata", oRData, 32'h0);
        chk("midrst_miss", oMissCount, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        iReq  = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        access(1'b0, 32'h40, 32'h0, 2, st, rq, rd);
        chk("post_rst_0x40_stalls", st, 3);
        chk("post_rst_0x40_rdata", rd, 32'hDEAD_BEEF);
        access(1'b0, 32'h50, 32'h0, 1, st, rq, rd);
        chk("dropped_ack_no_fill", st, 2);
        chk("post_rst_0x50_rdata", rd, memrd(32'h50));

        // Stray ack while idle must not disturb the arrays or the FSM
        iReq      = 1'b0;
        iAddr     = 32'h40;
        iMemAck   = 1'b1;
        iMemRData = 32'h0BAD_BAD0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("idle_ack_stall%0d", c), {31'b0, oStall}, 32'h0);
            chk($sformatf("idle_ack_req%0d", c), {31'b0, oMemReq}, 32'h0);
            @(posedge clk);
            #1;
        end
        iMemAck = 1'b0;
        access(1'b0, 32'h40, 32'h0, 1, st, rq, rd);
        chk("idle_ack_hit_stalls", st, 0);
        chk("idle_ack_hit_rdata", rd, 32'hDEAD_BEEF);
        access(1'b0, 32'h80, 32'h0, 1, st, rq, rd);
        chk("idle_ack_miss_stalls", st, 2);

        // Random stream against the reference cache
        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [31:0] addr;
            logic [31:0] wa;
            logic [31:0] wd;
            logic [31:0] exp_rd;
            int          dly;
            int          ix;
            logic [31:0] tg;
            logic        hit;
            we   = ($urandom_range(0, 9) < 3);
            tg   = 32'($urandom_range(0, 3));
            ix   = $urandom_range(0, 15);
            addr = tg * 64 + 32'(ix) * 4 + 32'($urandom_range(0, 3));
            wa   = addr & 32'hFFFF_FFFC;
            wd   = $urandom;
            dly  = $urandom_range(1, 4);
            hit  = m_valid[ix] && (m_tag[ix] == tg);
            exp_rd = hit ? m_data[ix] : memrd(wa);
            access(we, addr, wd, dly, st, rq, rd);
            if (we) begin
                chk($sformatf("rnd%0d_wr_stalls", n), st, dly + 1);
                chk($sformatf("rnd%0d_wr_reqs", n), rq, 1);
                if (hit) m_data[ix] = wd;
            end else begin
                chk($sformatf("rnd%0d_rd_stalls", n), st, hit ? 0 : dly + 1);
                chk($sformatf("rnd%0d_rd_reqs", n), rq, hit ? 0 : 1);
                chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
                if (hit) begin
                    m_hits++;
                end else begin
                    m_miss++;
                    m_valid[ix] = 1'b1;
                    m_tag[ix]   = tg;
                    m_data[ix]  = exp_rd;
                end
            end
        end
        @(negedge clk);
        chk("rnd_hits", oHitCount, PERF ? 32'(m_hits) : 32'd0);
        chk("rnd_miss", oMissCount, PERF ? 32'(m_miss) : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
